// File: rtl/epcs_flash_responder.sv
// Device end of an EPCS serial-flash link. Oversamples dclk/sce/sdo on clk_clk,
// decodes READ / READ_STATUS / READ_SILICON_ID and streams bytes from a byte-wide memory port.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | chip deselected, waiting for sce falling
// CMD       | shifting in the 8-bit opcode
// ADDR      | shifting in the 24-bit byte address (READ)
// DATA      | streaming memory bytes out, prefetching the next one
// STAT      | repeating the status byte
// SID_DUMMY | consuming 24 dummy bits before the silicon ID
// SID       | repeating the silicon ID byte
// IGNORE    | unsupported opcode, data0 held low until deselect
module epcs_flash_responder #(
    parameter int         ADDR_W     = 24,
    parameter logic [7:0] STATUS_VAL = 8'h00,
    parameter logic [7:0] SILICON_ID = 8'h10
) (
    input  logic              clk_clk,
    input  logic              reset_n_reset_n,
    input  logic              epcs_dclk,
    input  logic              epcs_sce,
    input  logic              epcs_sdo,
    output logic              epcs_data0,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic              active
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_STAT,
        S_SID_DUMMY,
        S_SID,
        S_IGNORE
    } state_t;

    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_STATUS = 8'h05;
    localparam logic [7:0] OP_SID    = 8'hAB;

    // WIP is never set: this device has no program/erase operations in flight.
    localparam logic [7:0] STATUS_BYTE = {STATUS_VAL[7:1], 1'b0};

    logic dclk_s1_q, dclk_s2_q, dclk_prev_q;
    logic sce_s1_q, sce_s2_q, sce_prev_q;
    logic sdo_s1_q, sdo_s2_q;

    always_ff @(posedge clk_clk or negedge reset_n_reset_n) begin
        if (!reset_n_reset_n) begin
            dclk_s1_q   <= 1'b0;
            dclk_s2_q   <= 1'b0;
            dclk_prev_q <= 1'b0;
            sce_s1_q    <= 1'b0;
            sce_s2_q    <= 1'b0;
            sce_prev_q  <= 1'b0;
            sdo_s1_q    <= 1'b0;
            sdo_s2_q    <= 1'b0;
        end else begin
            dclk_s1_q   <= epcs_dclk;
            dclk_s2_q   <= dclk_s1_q;
            dclk_prev_q <= dclk_s2_q;
            sce_s1_q    <= epcs_sce;
            sce_s2_q    <= sce_s1_q;
            sce_prev_q  <= sce_s2_q;
            sdo_s1_q    <= epcs_sdo;
            sdo_s2_q    <= sdo_s1_q;
        end
    end

    logic dclk_rise, dclk_fall, sce_fall;

    assign dclk_rise = dclk_s2_q & ~dclk_prev_q;
    assign dclk_fall = ~dclk_s2_q & dclk_prev_q;
    assign sce_fall  = ~sce_s2_q & sce_prev_q;

    state_t            state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [22:0]       shift_q, shift_d;
    logic [7:0]        tx_q, tx_d;
    logic [7:0]        hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_to_tx_q, rd_to_tx_d;
    logic              data0_q, data0_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              active_q, active_d;

    logic [23:0] bits_in;
    logic [7:0]  tx_src;
    logic        unused_addr_hi;

    // sdo_s2_q is aligned with dclk_s2_q, so it holds the bit present at the rising edge.
    assign bits_in        = {shift_q, sdo_s2_q};
    assign unused_addr_hi = bits_in[23];

    // At a byte boundary the prefetched byte (if any) replaces the drained tx register.
    assign tx_src = (bit_cnt_q == 5'd0 && hold_full_q) ? hold_q : tx_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rd_pend_d   = mem_rd_q;
        rd_to_tx_d  = rd_to_tx_q;
        data0_d     = data0_q;
        addr_d      = addr_q;
        mem_rd_d    = 1'b0;

        if (rd_pend_q) begin
            if (rd_to_tx_q) begin
                tx_d = mem_rdata;
            end else begin
                hold_d      = mem_rdata;
                hold_full_d = 1'b1;
            end
        end

        if (sce_s2_q) begin
            // Deselect overrides everything, including a coincident dclk edge.
            state_d     = S_IDLE;
            bit_cnt_d   = 5'd0;
            shift_d     = '0;
            tx_d        = '0;
            hold_d      = '0;
            hold_full_d = 1'b0;
            rd_pend_d   = 1'b0;
            rd_to_tx_d  = 1'b0;
            data0_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sce_fall) begin
                        state_d   = S_CMD;
                        bit_cnt_d = 5'd0;
                    end
                end
                S_CMD: begin
                    if (dclk_rise) begin
                        shift_d = bits_in[22:0];
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            case (bits_in[7:0])
                                OP_READ:   state_d = S_ADDR;
                                OP_STATUS: begin
                                    state_d = S_STAT;
                                    tx_d    = STATUS_BYTE;
                                end
                                OP_SID:    state_d = S_SID_DUMMY;
                                default:   state_d = S_IGNORE;
                            endcase
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                S_ADDR: begin
                    if (dclk_rise) begin
                        shift_d = bits_in[22:0];
                        if (bit_cnt_q == 5'd23) begin
                            addr_d      = bits_in[ADDR_W-1:0];
                            mem_rd_d    = 1'b1;
                            rd_to_tx_d  = 1'b1;
                            hold_full_d = 1'b0;
                            bit_cnt_d   = 5'd0;
                            state_d     = S_DATA;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (dclk_fall) begin
                        data0_d = tx_src[7];
                        tx_d    = {tx_src[6:0], 1'b0};
                        if (bit_cnt_q == 5'd0 && hold_full_q) begin
                            hold_full_d = 1'b0;
                        end
                        if (bit_cnt_q == 5'd7) begin
                            // Last bit of this byte is out: fetch the next one into the holding register.
                            bit_cnt_d  = 5'd0;
                            addr_d     = addr_q + ADDR_W'(1);
                            mem_rd_d   = 1'b1;
                            rd_to_tx_d = 1'b0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                S_STAT, S_SID: begin
                    if (dclk_fall) begin
                        data0_d = tx_q[7];
                        tx_d    = {tx_q[6:0], 1'b0};
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            tx_d      = (state_q == S_STAT) ? STATUS_BYTE : SILICON_ID;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                S_SID_DUMMY: begin
                    if (dclk_rise) begin
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = 5'd0;
                            tx_d      = SILICON_ID;
                            state_d   = S_SID;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                S_IGNORE: begin
                    data0_d = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        active_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_clk or negedge reset_n_reset_n) begin
        if (!reset_n_reset_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 5'd0;
            shift_q     <= '0;
            tx_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_to_tx_q  <= 1'b0;
            data0_q     <= 1'b0;
            addr_q      <= '0;
            mem_rd_q    <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rd_pend_q   <= rd_pend_d;
            rd_to_tx_q  <= rd_to_tx_d;
            data0_q     <= data0_d;
            addr_q      <= addr_d;
            mem_rd_q    <= mem_rd_d;
            active_q    <= active_d;
        end
    end

    assign epcs_data0 = data0_q;
    assign mem_addr   = addr_q;
    assign mem_rd     = mem_rd_q;
    assign active     = active_q;

endmodule

// File: tb/tb_epcs_flash_responder.sv
// Scoreboard bench: two responders (24-bit and 8-bit address) share one SPI master;
// expected data0 bytes and memory read addresses are queued at issue and checked by monitors.
module tb_epcs_flash_responder;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dclk = 1'b0;
    logic        sce = 1'b0;
    logic        sdo = 1'b0;

    logic        d24, d8, rd24, rd8, act24, act8;
    logic [23:0] addr24;
    logic [7:0]  addr8;
    logic [7:0]  rdata24 = 8'h00;
    logic [7:0]  rdata8 = 8'h00;

    int          n_cmp = 0;
    int          n_mis = 0;
    bit          mon_en = 1'b0;

    logic [7:0]  qb24[$];
    logic [7:0]  qb8[$];
    logic [23:0] qa24[$];
    logic [23:0] qa8[$];

    always #5 clk = ~clk;

    epcs_flash_responder #(.ADDR_W(24), .STATUS_VAL(8'h00), .SILICON_ID(8'h10)) dut24 (
        .clk_clk(clk), .reset_n_reset_n(rst_n),
        .epcs_dclk(dclk), .epcs_sce(sce), .epcs_sdo(sdo), .epcs_data0(d24),
        .mem_addr(addr24), .mem_rd(rd24), .mem_rdata(rdata24), .active(act24));

    epcs_flash_responder #(.ADDR_W(8), .STATUS_VAL(8'h5A), .SILICON_ID(8'h14)) dut8 (
        .clk_clk(clk), .reset_n_reset_n(rst_n),
        .epcs_dclk(dclk), .epcs_sce(sce), .epcs_sdo(sdo), .epcs_data0(d8),
        .mem_addr(addr8), .mem_rd(rd8), .mem_rdata(rdata8), .active(act8));

    function automatic logic [7:0] mem_f(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16];
    endfunction

    // Memory answers one clock after the strobe; otherwise the bus carries noise.
    always @(posedge clk) begin
        rdata24 <= rd24 ? mem_f(addr24) : 8'($urandom);
        rdata8  <= rd8  ? mem_f({16'h0, addr8}) : 8'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic miss(input string name, input logic [31:0] act);
        n_cmp++;
        n_mis++;
        $display("FAIL %s: actual event value %0h, required no event (queue empty)", name, act);
    endtask

    // Expected byte seen by the master during byte slot idx of a transaction.
    function automatic logic [7:0] exp_byte(input logic [7:0] op, input logic [23:0] a,
                                            input int abits, input int idx, input int w,
                                            input logic [7:0] stat, input logic [7:0] sid);
        logic [23:0] x;
        if (idx == 0) return 8'h00;
        case (op)
            8'h03: begin
                if (abits != 24 || idx < 4) return 8'h00;
                x = a + 24'(idx - 4);
                if (w == 8) x = x & 24'h0000FF;
                return mem_f(x);
            end
            8'h05:   return {stat[7:1], 1'b0};
            8'hAB:   return (idx >= 4) ? sid : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    int          bitn = 0;
    logic [7:0]  sh24 = 8'h00;
    logic [7:0]  sh8 = 8'h00;

    always @(posedge dclk or posedge sce) begin
        if (sce) begin
            bitn = 0;
        end else if (mon_en) begin
            sh24 = {sh24[6:0], d24};
            sh8  = {sh8[6:0], d8};
            bitn++;
            if (bitn == 8) begin
                bitn = 0;
                if (qb24.size() == 0) miss("data24_byte", {24'h0, sh24});
                else chk("data24_byte", {24'h0, sh24}, {24'h0, qb24.pop_front()});
                if (qb8.size() == 0) miss("data8_byte", {24'h0, sh8});
                else chk("data8_byte", {24'h0, sh8}, {24'h0, qb8.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (rd24) begin
            if (qa24.size() == 0) miss("rd24_addr", {8'h0, addr24});
            else chk("rd24_addr", {8'h0, addr24}, {8'h0, qa24.pop_front()});
        end
        if (rd8) begin
            if (qa8.size() == 0) miss("rd8_addr", {24'h0, addr8});
            else chk("rd8_addr", {24'h0, addr8}, {8'h0, qa8.pop_front()});
        end
    end

    task automatic txn(input logic [7:0] op, input logic [23:0] a, input int abits, input int tail);
        int nrise;
        logic [23:0] x;
        nrise = 8 + abits + 8 * tail;
        for (int i = 0; i < nrise / 8; i++) begin
            qb24.push_back(exp_byte(op, a, abits, i, 24, 8'h00, 8'h10));
            qb8.push_back(exp_byte(op, a, abits, i, 8, 8'h5A, 8'h14));
        end
        if (op == 8'h03 && abits == 24) begin
            for (int k = 0; k <= tail; k++) begin
                x = a + 24'(k);
                qa24.push_back(x);
                qa8.push_back(x & 24'h0000FF);
            end
        end
        @(negedge clk);
        sce = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < nrise; b++) begin
            if (b < 8) sdo = op[7-b];
            else if (b < 8 + abits) sdo = a[23-(b-8)];
            else sdo = 1'($urandom_range(0, 1));
            repeat (HALF) @(negedge clk);
            dclk = 1'b1;
            repeat (HALF) @(negedge clk);
            dclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        chk("active24_busy", {31'h0, act24}, 32'h1);
        chk("active8_busy", {31'h0, act8}, 32'h1);
        sce = 1'b1;
        repeat (3) @(negedge clk);
        chk("active24_release", {31'h0, act24}, 32'h0);
        chk("active8_release", {31'h0, act8}, 32'h0);
        chk("data24_release", {31'h0, d24}, 32'h0);
        chk("data8_release", {31'h0, d8}, 32'h0);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int          kind;
        logic [23:0] ra;
        logic [7:0]  op;

        // Reset held with the chip selected and dclk running: outputs must stay quiet.
        for (int i = 0; i < 6; i++) begin
            repeat (4) @(negedge clk);
            dclk = ~dclk;
            sdo  = 1'($urandom_range(0, 1));
            chk("rst_data24", {31'h0, d24}, 32'h0);
            chk("rst_rd24", {31'h0, rd24}, 32'h0);
            chk("rst_active24", {31'h0, act24}, 32'h0);
            chk("rst_data8", {31'h0, d8}, 32'h0);
            chk("rst_rd8", {31'h0, rd8}, 32'h0);
            chk("rst_active8", {31'h0, act8}, 32'h0);
        end
        dclk = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // No sce falling edge has been seen, so both stay idle.
        for (int i = 0; i < 4; i++) begin
            repeat (HALF) @(negedge clk);
            dclk = ~dclk;
            chk("idle_after_rst24", {31'h0, act24}, 32'h0);
            chk("idle_after_rst8", {31'h0, act8}, 32'h0);
        end
        dclk = 1'b0;
        sce  = 1'b1;
        repeat (8) @(negedge clk);
        mon_en = 1'b1;

        txn(8'h03, 24'h000010, 24, 4);
        txn(8'h03, 24'hAA00FE, 24, 3);
        txn(8'h05, 24'h000000, 0, 3);
        txn(8'hAB, 24'h000000, 0, 5);
        txn(8'h06, 24'h000000, 0, 2);
        txn(8'h03, 24'h000020, 12, 0);
        txn(8'h03, 24'h000020, 24, 1);

        for (int t = 0; t < 20; t++) begin
            kind = int'($urandom_range(0, 4));
            ra   = 24'($urandom);
            case (kind)
                0: txn(8'h03, ra, 24, int'($urandom_range(1, 4)));
                1: txn(8'h05, ra, 0, int'($urandom_range(1, 3)));
                2: txn(8'hAB, ra, 0, 3 + int'($urandom_range(1, 2)));
                3: begin
                    op = 8'($urandom);
                    while (op == 8'h03 || op == 8'h05 || op == 8'hAB) op = 8'($urandom);
                    txn(op, ra, 0, int'($urandom_range(0, 3)));
                end
                default: txn(8'h03, ra, int'($urandom_range(1, 23)), 0);
            endcase
        end

        repeat (20) @(negedge clk);
        chk("bytes24_left", qb24.size(), 32'h0);
        chk("bytes8_left", qb8.size(), 32'h0);
        chk("rd24_left", qa24.size(), 32'h0);
        chk("rd8_left", qa8.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
